// File: rtl/tile_ram_writer.sv
// rtl/tile_ram_writer.sv - CPU write FIFO plus block-fill engine draining into the tile RAM
// Writes are issued only on edges where the renderer leaves ram_busy low.
module tile_ram_writer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [CNT_W-1:0]  fill_count,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   input  logic              ram_busy,
   input  logic [ADDR_W-1:0] render_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_write,
   output logic              ram_writeenable
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state;
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [ADDR_W-1:0] fill_addr;
   logic [CNT_W-1:0]  fill_left;
   logic [DATA_W-1:0] fill_word;
   logic [ADDR_W-1:0] wq_addr;
   logic              push;
   logic              pop;
   logic              fill_issue;

   // wr_ready looks at the pre-pop count, so a full FIFO refuses even while draining
   assign wr_ready   = (count != (PTR_W+1)'(FIFO_DEPTH));
   assign push       = wr_valid && wr_ready;
   assign fill_issue = !ram_busy && (state == FILL);
   assign pop        = !ram_busy && (state == IDLE) && (count != '0);
   assign ram_addr   = ram_writeenable ? wq_addr : render_addr;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         fill_addr       <= '0;
         fill_left       <= '0;
         fill_word       <= '0;
         fill_busy       <= 1'b0;
         wq_addr         <= '0;
         ram_write       <= '0;
         ram_writeenable <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         ram_writeenable <= fill_issue || pop;
         if (fill_issue) begin
            wq_addr   <= fill_addr;
            ram_write <= fill_word;
         end else if (pop) begin
            wq_addr   <= fifo_addr[rd_ptr];
            ram_write <= fifo_data[rd_ptr];
         end

         case (state)
            IDLE: begin
               if (fill_start && (fill_count != '0)) begin
                  state     <= FILL;
                  fill_busy <= 1'b1;
                  fill_addr <= fill_base;
                  fill_left <= fill_count;
                  fill_word <= fill_value;
               end
            end
            FILL: begin
               if (fill_issue) begin
                  fill_addr <= fill_addr + 1'b1;
                  fill_left <= fill_left - 1'b1;
                  if (fill_left == CNT_W'(1)) begin
                     state     <= IDLE;
                     fill_busy <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_ram_writer.sv
// tb/tb_tile_ram_writer.sv - scoreboard bench for tile_ram_writer
module tb_tile_ram_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        fill_start;
   logic [15:0] fill_base;
   logic [10:0] fill_count;
   logic [15:0] fill_value;
   logic        fill_busy;
   logic        ram_busy;
   logic [15:0] render_addr;
   logic [15:0] ram_addr;
   logic [15:0] ram_write;
   logic        ram_writeenable;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] ram_model [int];
   logic        busy_at_edge = 1'b0;
   int          checks = 0;
   int          errors = 0;

   tile_ram_writer dut (
      .clk             (clk),
      .reset           (reset),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .fill_start      (fill_start),
      .fill_base       (fill_base),
      .fill_count      (fill_count),
      .fill_value      (fill_value),
      .fill_busy       (fill_busy),
      .ram_busy        (ram_busy),
      .render_addr     (render_addr),
      .ram_addr        (ram_addr),
      .ram_write       (ram_write),
      .ram_writeenable (ram_writeenable)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // RAM model and the busy level seen at each issue edge
   always @(posedge clk) begin
      busy_at_edge <= ram_busy;
      if (ram_writeenable)
         ram_model[int'(ram_addr)] = ram_write;
   end

   always @(negedge clk) begin
      if (reset && ram_writeenable) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h:%h required=none", ram_addr, ram_write);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(ram_addr), 32'(e.a));
            check("write_data", 32'(ram_write), 32'(e.d));
         end
         check("issued_while_busy", 32'(busy_at_edge), 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] a, input logic [15:0] d, output bit acc);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      acc      = wr_ready;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic start_fill(input logic [15:0] base, input logic [10:0] cnt, input logic [15:0] val);
      fill_start = 1'b1;
      fill_base  = base;
      fill_count = cnt;
      fill_value = val;
      step();
      fill_start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit  acc;
      wr_t held;

      reset       = 1'b0;
      wr_valid    = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      fill_start  = 1'b0;
      fill_base   = '0;
      fill_count  = '0;
      fill_value  = '0;
      ram_busy    = 1'b0;
      render_addr = 16'h5555;

      // reset held: a write pulse must not reach the RAM
      step();
      wr_valid = 1'b1;
      wr_addr  = 16'h0001;
      wr_data  = 16'h0BAD;
      step();
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_we", 32'(ram_writeenable), 32'd0);
      check("rst_fill_busy", 32'(fill_busy), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_ram_addr_mux", 32'(ram_addr), 32'h5555);
      wr_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      step();

      // single CPU write
      push_word(16'h0010, 16'h1F41, acc);
      check("t2_accept", 32'(acc), 32'd1);
      if (acc) exp_q.push_back('{a: 16'h0010, d: 16'h1F41});
      check("t2_we_early", 32'(ram_writeenable), 32'd0);
      step();
      check("t2_we", 32'(ram_writeenable), 32'd1);
      check("t2_addr", 32'(ram_addr), 32'h0010);
      check("t2_din", 32'(ram_write), 32'h1F41);
      step();
      check("t2_ram", 32'(ram_model.exists(16) ? ram_model[16] : 16'hxxxx), 32'h1F41);
      check("t2_addr_back_to_render", 32'(ram_addr), 32'h5555);

      // fill the FIFO while the renderer holds the RAM
      ram_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_word(16'h0100 + 16'(i), 16'hA000 + 16'(i), acc);
         check("t3_accept", 32'(acc), 32'd1);
         if (acc) exp_q.push_back('{a: 16'h0100 + 16'(i), d: 16'hA000 + 16'(i)});
      end
      check("t3_full", 32'(wr_ready), 32'd0);
      push_word(16'h01FF, 16'hDEAD, acc);
      check("t3_ninth_refused", 32'(acc), 32'd0);
      check("t3_no_we_while_busy", 32'(ram_writeenable), 32'd0);
      ram_busy = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         check("t3_burst_we", 32'(ram_writeenable), 32'd1);
         step();
      end
      check("t3_burst_end", 32'(ram_writeenable), 32'd0);
      check("t3_ready_again", 32'(wr_ready), 32'd1);

      // 32-word fill with the renderer toggling busy
      for (int i = 0; i < 32; i++)
         exp_q.push_back('{a: 16'h7E00 + 16'(i), d: 16'h0720});
      start_fill(16'h7E00, 11'd32, 16'h0720);
      check("t4_fill_busy", 32'(fill_busy), 32'd1);
      for (int cyc = 0; cyc < 400 && fill_busy; cyc++) begin
         ram_busy = ((cyc % 7) >= 4);
         step();
      end
      ram_busy = 1'b0;
      check("t4_fill_done", 32'(fill_busy), 32'd0);
      step();
      step();
      check("t4_all_written", 32'(exp_q.size()), 32'd0);

      // FIFO entry pushed before a fill drains only after the fill
      ram_busy = 1'b1;
      push_word(16'h0300, 16'h1111, acc);
      held = '{a: 16'h0300, d: 16'h1111};
      start_fill(16'h0300, 11'd2, 16'h2222);
      exp_q.push_back('{a: 16'h0300, d: 16'h2222});
      exp_q.push_back('{a: 16'h0301, d: 16'h2222});
      if (acc) exp_q.push_back(held);
      ram_busy = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("t4b_order_drained", 32'(exp_q.size()), 32'd0);
      check("t4b_ram_last_wins", 32'(ram_model.exists(16'h0300) ? ram_model[16'h0300] : 16'hxxxx), 32'h1111);

      // address wrap and a fill_start ignored mid-fill
      exp_q.push_back('{a: 16'hFFFE, d: 16'hABCD});
      exp_q.push_back('{a: 16'hFFFF, d: 16'hABCD});
      exp_q.push_back('{a: 16'h0000, d: 16'hABCD});
      exp_q.push_back('{a: 16'h0001, d: 16'hABCD});
      start_fill(16'hFFFE, 11'd4, 16'hABCD);
      check("t5_fill_busy", 32'(fill_busy), 32'd1);
      start_fill(16'h1234, 11'd3, 16'h5555);
      for (int i = 0; i < 6; i++) step();
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      check("t5_fill_done", 32'(fill_busy), 32'd0);

      // zero-length fill is a no-op
      start_fill(16'h2000, 11'd0, 16'h7777);
      check("t5_zero_count", 32'(fill_busy), 32'd0);
      for (int i = 0; i < 4; i++) step();

      // reset in the middle of a fill
      for (int i = 0; i < 20; i++)
         exp_q.push_back('{a: 16'h4000 + 16'(i), d: 16'h3333});
      start_fill(16'h4000, 11'd20, 16'h3333);
      step();
      step();
      step();
      reset = 1'b0;
      #1;
      check("t6_fill_busy", 32'(fill_busy), 32'd0);
      check("t6_we", 32'(ram_writeenable), 32'd0);
      check("t6_ready", 32'(wr_ready), 32'd1);
      exp_q.delete();
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("t6_no_writes", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
